mem_responder: RTL and testbench

//  - Word-addressed 32-bit data/instruction memory, responder side of the core's memory request interface.
//  - Serves fetch (phase f) and load/store (phase m) requests issued by the micro core.
//  - Single outstanding request. Programmable wait states. One-cycle response pulse.
//  - Sits beside register_file/alu under the micro top; replaces the direct ma/md_in/md_out wiring.

---
 rtl/micro_pkg.sv | 23 ++
 rtl/mem_array.sv | 36 +++
 rtl/mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_mem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared definitions for the micro core: pipeline phase indices, memory
// responder FSM states and default bus widths.
package micro_pkg;

    // Phase index constants
    localparam int unsigned PH_F = 4;
    localparam int unsigned PH_R = 3;
    localparam int unsigned PH_X = 2;
    localparam int unsigned PH_M = 1;
    localparam int unsigned PH_W = 0;

    // Default memory bus widths (word address, data)
    localparam int unsigned AW_DEFAULT = 8;
    localparam int unsigned DW_DEFAULT = 32;

    // Memory responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DW storage: one synchronous write port, one synchronous read port
// with read enable, no reset so it maps onto block RAM.
module mem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned DW    = 32,
    parameter int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [IW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port; the output register holds until the next enabled read
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder for the micro core's fetch/load/store
// interface. Single outstanding request, WAIT_CYCLES wait states, one-cycle
// response pulse. Optional out-of-range error reporting under MEM_RESP_ERR_EN.
module mem_responder
    import micro_pkg::*;
#(
    parameter int unsigned AW          = AW_DEFAULT,
    parameter int unsigned DW          = DW_DEFAULT,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata
`ifdef MEM_RESP_ERR_EN
    ,
    output logic          rsp_err
`endif
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = 4;
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        ZERO_WAIT ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic             rsp_valid_q;
    logic             src_ram_q;
    logic [DW-1:0]    data_q;

    logic             accept_c;
    logic             commit_c;
    logic             cmd_we_c;
    logic [AW-1:0]    cmd_addr_c;
    logic [DW-1:0]    cmd_wdata_c;
    logic             oor_c;
    logic [DW-1:0]    ram_rdata;

    assign accept_c = req_valid && ready_q;

    // With no wait states the commit happens on the accepting edge, so the
    // command comes straight from the request port instead of the latch.
    assign cmd_we_c    = ZERO_WAIT ? req_we    : we_q;
    assign cmd_addr_c  = ZERO_WAIT ? req_addr  : addr_q;
    assign cmd_wdata_c = ZERO_WAIT ? req_wdata : wdata_q;

`ifdef MEM_RESP_ERR_EN
    // Address is out of range when any bit above the index field is set
    assign oor_c = (IDX_W < AW) ? (|(cmd_addr_c >> IDX_W)) : 1'b0;
`else
    assign oor_c = 1'b0;
`endif

    // Next-state logic: accept, wait countdown, commit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept_c) begin
                    if (ZERO_WAIT) begin
                        state_d  = RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and ready registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d != WAIT);
        end
    end

    // Request latch, loaded only on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept_c) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Response registers; read data is taken from the RAM output register,
    // store data and error zeros from data_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            src_ram_q   <= 1'b0;
            data_q      <= '0;
        end else begin
            rsp_valid_q <= commit_c;
            if (commit_c) begin
                if (oor_c) begin
                    src_ram_q <= 1'b0;
                    data_q    <= '0;
                end else if (cmd_we_c) begin
                    src_ram_q <= 1'b0;
                    data_q    <= cmd_wdata_c;
                end else begin
                    src_ram_q <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_RESP_ERR_EN
    logic rsp_err_q;

    // Error flag qualifies only the response cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= commit_c && oor_c;
        end
    end

    assign rsp_err = rsp_err_q;
`endif

    mem_array #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .IW    (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (commit_c && cmd_we_c && !oor_c),
        .waddr_i (cmd_addr_c[IDX_W-1:0]),
        .wdata_i (cmd_wdata_c),
        .re_i    (commit_c && !cmd_we_c && !oor_c),
        .raddr_i (cmd_addr_c[IDX_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = src_ram_q ? ram_rdata : data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder. Three instances:
// 0: WAIT_CYCLES=1, DEPTH=256; 1: WAIT_CYCLES=0, DEPTH=64; 2: WAIT_CYCLES=3, DEPTH=256.
module tb_mem_responder;

    localparam int WC [3] = '{1, 0, 3};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld   [3];
    logic        we    [3];
    logic [7:0]  addr  [3];
    logic [31:0] wdata [3];
    logic        rdy   [3];
    logic        rvld  [3];
    logic [31:0] rdata [3];
`ifdef MEM_RESP_ERR_EN
    logic        err   [3];
`endif

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_responder #(.AW(8), .DW(32), .DEPTH(256), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we[0]),
        .req_addr(addr[0]), .req_wdata(wdata[0]), .rsp_valid(rvld[0]), .rsp_rdata(rdata[0])
`ifdef MEM_RESP_ERR_EN
        , .rsp_err(err[0])
`endif
    );

    mem_responder #(.AW(8), .DW(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we[1]),
        .req_addr(addr[1]), .req_wdata(wdata[1]), .rsp_valid(rvld[1]), .rsp_rdata(rdata[1])
`ifdef MEM_RESP_ERR_EN
        , .rsp_err(err[1])
`endif
    );

    mem_responder #(.AW(8), .DW(32), .DEPTH(256), .WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(we[2]),
        .req_addr(addr[2]), .req_wdata(wdata[2]), .rsp_valid(rvld[2]), .rsp_rdata(rdata[2])
`ifdef MEM_RESP_ERR_EN
        , .rsp_err(err[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        sb_q.push_back(x);
    endtask

    // Compare the response currently on instance i against the scoreboard head
    task automatic take_rsp(input int i, input string tag);
        exp_t x;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            check({tag, "_rdata"}, rdata[i], x.rdata);
`ifdef MEM_RESP_ERR_EN
            check({tag, "_err"}, 32'(err[i]), 32'(x.err));
`endif
        end
    endtask

    // Full transaction on instance i, entered and left at a negedge
    task automatic xact(input int i, input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
        int n;
        vld[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        push_exp(exp_d, exp_e);
        n = 0;
        while (rdy[i] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, "_accept"}, 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        vld[i] = 1'b0;
        n = 0;
        while (rvld[i] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check({tag, "_latency"}, 32'(n + 1), 32'(WC[i] + 1));
        take_rsp(i, tag);
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(rvld[i]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        logic [31:0] v41, v01;
        logic        e41;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_ready%0d", i), 32'(rdy[i]), 32'd1);
            check($sformatf("reset_valid%0d", i), 32'(rvld[i]), 32'd0);
            check($sformatf("reset_rdata%0d", i), rdata[i], 32'd0);
`ifdef MEM_RESP_ERR_EN
            check($sformatf("reset_err%0d", i), 32'(err[i]), 32'd0);
`endif
        end
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-WAIT of a store drops it
        xact(0, 1'b1, 8'h05, 32'h1111_1111, 32'h1111_1111, 1'b0, "t1_preload");
        vld[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h05; wdata[0] = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        check("t1_in_wait", 32'(rdy[0]), 32'd0);
        vld[0] = 1'b0;
        rst = 1'b0;
        #1;
        check("t1_rst_ready", 32'(rdy[0]), 32'd1);
        check("t1_rst_valid", 32'(rvld[0]), 32'd0);
        check("t1_rst_rdata", rdata[0], 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hits = 0;
        repeat (4) begin
            @(negedge clk);
            if (rvld[0] === 1'b1) hits++;
        end
        check("t1_no_store_rsp", 32'(hits), 32'd0);
        xact(0, 1'b0, 8'h05, 32'h0, 32'h1111_1111, 1'b0, "t1_load_old");

        // WAIT_CYCLES=1 store then load
        xact(0, 1'b1, 8'h10, 32'h1234_5678, 32'h1234_5678, 1'b0, "t2_store");
        xact(0, 1'b0, 8'h10, 32'h0, 32'h1234_5678, 1'b0, "t2_load");

        // Load accepted in the RESP cycle of a store to the same address
        vld[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 32'hCAFE_F00D;
        push_exp(32'hCAFE_F00D, 1'b0);
        @(posedge clk);
        @(negedge clk);
        we[0] = 1'b0; wdata[0] = 32'h0;
        push_exp(32'hCAFE_F00D, 1'b0);
        check("t6_wait_ready", 32'(rdy[0]), 32'd0);
        check("t6_wait_valid", 32'(rvld[0]), 32'd0);
        @(negedge clk);
        check("t6_resp_valid", 32'(rvld[0]), 32'd1);
        check("t6_resp_ready", 32'(rdy[0]), 32'd1);
        take_rsp(0, "t6_store");
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        check("t6_load_wait", 32'(rvld[0]), 32'd0);
        @(negedge clk);
        check("t6_load_valid", 32'(rvld[0]), 32'd1);
        take_rsp(0, "t6_load");
        @(negedge clk);

        // WAIT_CYCLES=0: preload addr*3 then back-to-back loads
        for (int i = 0; i < 8; i++) begin
            xact(1, 1'b1, 8'(i), 32'(i * 3), 32'(i * 3), 1'b0, $sformatf("t3_pre%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            vld[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'(i);
            push_exp(32'(i * 3), 1'b0);
            check($sformatf("t3_ready%0d", i), 32'(rdy[1]), 32'd1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t3_valid%0d", i), 32'(rvld[1]), 32'd1);
            take_rsp(1, $sformatf("t3_load%0d", i));
        end
        vld[1] = 1'b0;
        @(negedge clk);
        check("t3_idle", 32'(rvld[1]), 32'd0);

        // DEPTH=64: store to 0x41
`ifdef MEM_RESP_ERR_EN
        v41 = 32'h0; e41 = 1'b1; v01 = 32'd3;
`else
        v41 = 32'hAAAA_5555; e41 = 1'b0; v01 = 32'hAAAA_5555;
`endif
        xact(1, 1'b1, 8'h41, 32'hAAAA_5555, v41, e41, "t5_store41");
        xact(1, 1'b0, 8'h01, 32'h0, v01, 1'b0, "t5_load01");
        xact(1, 1'b0, 8'h41, 32'h0, v41, e41, "t5_load41");

        // WAIT_CYCLES=3: request held during WAIT
        xact(2, 1'b1, 8'h30, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0, "t4_pre30");
        xact(2, 1'b1, 8'h31, 32'h55AA_00FF, 32'h55AA_00FF, 1'b0, "t4_pre31");
        vld[2] = 1'b1; we[2] = 1'b0; addr[2] = 8'h30;
        push_exp(32'h0BAD_CAFE, 1'b0);
        @(posedge clk);
        @(negedge clk);
        addr[2] = 8'h31;
        push_exp(32'h55AA_00FF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t4_wait_ready%0d", k), 32'(rdy[2]), 32'd0);
            check($sformatf("t4_wait_valid%0d", k), 32'(rvld[2]), 32'd0);
            @(negedge clk);
        end
        check("t4_first_valid", 32'(rvld[2]), 32'd1);
        check("t4_first_ready", 32'(rdy[2]), 32'd1);
        take_rsp(2, "t4_first");
        @(posedge clk);
        @(negedge clk);
        vld[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t4_second_wait%0d", k), 32'(rvld[2]), 32'd0);
            @(negedge clk);
        end
        check("t4_second_valid", 32'(rvld[2]), 32'd1);
        take_rsp(2, "t4_second");
        @(negedge clk);
        check("t4_second_pulse_end", 32'(rvld[2]), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
